// File: rtl/mem_init_sequencer.sv
// mem_init_sequencer: startup sequencer for the AXI memory slave.
// Synchronises init_calib_complete, waits for it to stay high for a settle
// window, sweeps the backing memory with zero writes, then raises mem_ready.
// Raises sticky flags when calibration never arrives or is later lost.
module mem_init_sequencer #(
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned SETTLE_CYCLES  = 16,
    parameter int unsigned ADDR_WIDTH     = 10,
    parameter int unsigned CLEAR_DEPTH    = 1024,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  init_calib_complete,
    output logic                  clr_wr_en,
    output logic [ADDR_WIDTH-1:0] clr_addr,
    output logic [DATA_WIDTH-1:0] clr_wr_data,
    input  logic                  clr_wr_ready,
    output logic                  mem_ready,
    output logic                  calib_timeout,
    output logic                  calib_lost,
    output logic [1:0]            state
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETTLE = 2'd1;
    localparam logic [1:0] S_CLEAR  = 2'd2;
    localparam logic [1:0] S_READY  = 2'd3;

    localparam int unsigned STW = $clog2(SETTLE_CYCLES + 1);
    localparam int unsigned TOW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [STW-1:0]        SETTLE_MAX = STW'(SETTLE_CYCLES);
    localparam logic [STW-1:0]        SETTLE_ONE = STW'(1);
    localparam logic [TOW-1:0]        TO_MAX     = TOW'(TIMEOUT_CYCLES - 1);
    localparam logic [TOW-1:0]        TO_ONE     = TOW'(1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST  = ADDR_WIDTH'(CLEAR_DEPTH - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE   = ADDR_WIDTH'(1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_cal_s;
    logic [1:0]             r_state;
    logic [STW-1:0]         r_settle;
    logic [TOW-1:0]         r_to_cnt;
    logic                   r_timeout;
    logic [ADDR_WIDTH-1:0]  r_addr;
    logic                   r_en;
    logic                   r_mem_ready;
    logic                   r_lost;

    assign w_cal_s = r_sync[SYNC_STAGES-1];

    // Shift the asynchronous calibration flag through the synchroniser chain
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], init_calib_complete};
        end
    end

    // Count time spent in IDLE; restart on every IDLE entry, flag saturation stickily
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_to_cnt  <= '0;
            r_timeout <= 1'b0;
        end else if (r_state == S_IDLE) begin
            if (r_to_cnt == TO_MAX) begin
                r_timeout <= 1'b1;
            end else begin
                r_to_cnt <= r_to_cnt + TO_ONE;
            end
        end else begin
            r_to_cnt <= '0;
        end
    end

    // Sequencer: settle window, clearing sweep, ready hand-off and loss detection
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_settle    <= '0;
            r_addr      <= '0;
            r_en        <= 1'b0;
            r_mem_ready <= 1'b0;
            r_lost      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_en        <= 1'b0;
                    r_mem_ready <= 1'b0;
                    if (w_cal_s) begin
                        r_state  <= S_SETTLE;
                        r_settle <= SETTLE_ONE;
                    end
                end
                S_SETTLE: begin
                    if (!w_cal_s) begin
                        r_state  <= S_IDLE;
                        r_settle <= '0;
                    end else if (r_settle == SETTLE_MAX) begin
                        r_state  <= S_CLEAR;
                        r_settle <= '0;
                        r_addr   <= '0;
                        r_en     <= 1'b1;
                    end else begin
                        r_settle <= r_settle + SETTLE_ONE;
                    end
                end
                S_CLEAR: begin
                    // Loss is tested before the handshake so a dropped cycle's write is discarded
                    if (!w_cal_s) begin
                        r_state <= S_IDLE;
                        r_en    <= 1'b0;
                        r_addr  <= '0;
                        r_lost  <= 1'b1;
                    end else if (r_en && clr_wr_ready) begin
                        if (r_addr == ADDR_LAST) begin
                            r_state <= S_READY;
                            r_en    <= 1'b0;
                        end else begin
                            r_addr <= r_addr + ADDR_ONE;
                        end
                    end
                end
                S_READY: begin
                    r_en <= 1'b0;
                    if (!w_cal_s) begin
                        r_state     <= S_IDLE;
                        r_mem_ready <= 1'b0;
                        r_lost      <= 1'b1;
                    end else begin
                        r_mem_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_en    <= 1'b0;
                end
            endcase
        end
    end

    assign clr_wr_en     = r_en;
    assign clr_addr      = r_addr;
    assign clr_wr_data   = '0;
    assign mem_ready     = r_mem_ready;
    assign calib_timeout = r_timeout;
    assign calib_lost    = r_lost;
    assign state         = r_state;

endmodule

// File: tb/tb_mem_init_sequencer.sv
// Testbench for mem_init_sequencer: random handshake stimulus, scoreboard of
// expected clear-write addresses, latency and sticky-flag checks.
module tb_mem_init_sequencer;

    localparam int unsigned SYNC   = 2;
    localparam int unsigned SETTLE = 16;
    localparam int unsigned AW     = 10;
    localparam int unsigned DEPTH  = 1024;
    localparam int unsigned DW     = 32;
    localparam int unsigned TOUT   = 4096;

    logic          clk   = 1'b0;
    logic          reset = 1'b1;
    logic          calib = 1'b0;
    logic          ready = 1'b0;
    logic          en;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          mrdy;
    logic          tmo;
    logic          lost;
    logic [1:0]    st;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned cyc      = 0;
    int unsigned base     = 0;
    int unsigned acc      = 0;
    int unsigned pat_i    = 0;
    int unsigned ready_mode = 0;
    int unsigned exp_q[$];
    logic        hold_chk = 1'b0;
    logic        p_stall  = 1'b0;
    logic [AW-1:0] p_addr = '0;

    mem_init_sequencer #(
        .SYNC_STAGES   (SYNC),
        .SETTLE_CYCLES (SETTLE),
        .ADDR_WIDTH    (AW),
        .CLEAR_DEPTH   (DEPTH),
        .DATA_WIDTH    (DW),
        .TIMEOUT_CYCLES(TOUT)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .init_calib_complete(calib),
        .clr_wr_en          (en),
        .clr_addr           (addr),
        .clr_wr_data        (data),
        .clr_wr_ready       (ready),
        .mem_ready          (mrdy),
        .calib_timeout      (tmo),
        .calib_lost         (lost),
        .state              (st)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every accepted write must be the next expected address with zero data
    always @(negedge clk) begin
        if (reset) begin
            p_stall = 1'b0;
        end else begin
            if (hold_chk && p_stall) begin
                check("stall_hold_en", en, 1);
                check("stall_hold_addr", addr, p_addr);
            end
            if (en && ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL extra_write: addr %0d written while no write expected", addr);
                end else begin
                    check("clr_addr", addr, exp_q.pop_front());
                    check("clr_wr_data", data, 0);
                end
                acc++;
            end
            p_stall = en && !ready;
            p_addr  = addr;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        case (ready_mode)
            0: ready = 1'b1;
            1: begin
                ready = ((pat_i % 4) == 0) || ((pat_i % 4) == 3);
                pat_i++;
            end
            2: ready = 1'($urandom_range(0, 1));
            default: ready = 1'b0;
        endcase
    endtask

    task automatic push_sweep();
        for (int unsigned a = 0; a < DEPTH; a++) exp_q.push_back(a);
        acc = 0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        calib = 1'b0;
        exp_q.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        base  = cyc;
        acc   = 0;
    endtask

    task automatic wait_mrdy(input int unsigned limit);
        int unsigned n;
        n = 0;
        while (!mrdy && n < limit) begin
            step();
            n++;
        end
        check("mem_ready_reached", mrdy, 1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_en"}, en, 0);
        check({tag, "_addr"}, addr, 0);
        check({tag, "_mem_ready"}, mrdy, 0);
        check({tag, "_timeout"}, tmo, 0);
        check({tag, "_lost"}, lost, 0);
        check({tag, "_state"}, st, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned first_en;
        int unsigned first_rdy;
        int unsigned k;
        int unsigned plen;
        int unsigned n;
        logic saw_settle;
        logic saw_en;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        do_reset();
        check_all_zero("post_reset");

        // 1: ready tied high, calibration rises at cycle 100
        ready_mode = 0;
        ready = 1'b1;
        while (cyc - base < 100) step();
        calib = 1'b1;
        push_sweep();
        first_en  = 0;
        first_rdy = 0;
        for (int i = 0; i < 3000; i++) begin
            step();
            k = cyc - base;
            if (en && first_en == 0) first_en = k;
            if (mrdy) begin
                first_rdy = k;
                break;
            end
        end
        check("first_clr_wr_en_cycle", first_en, 100 + SYNC + SETTLE + 1);
        check("mem_ready_cycle", first_rdy, 100 + SYNC + SETTLE + 1 + DEPTH + 1);
        check("t1_accepts", acc, DEPTH);
        check("t1_queue_left", exp_q.size(), 0);
        check("t1_en_in_ready", en, 0);
        check("t1_state", st, 3);
        check("t1_lost", lost, 0);

        // 2: calibration glitch shorter than the settle window
        do_reset();
        ready_mode = 0;
        repeat (5) step();
        plen = $urandom_range(1, SETTLE - 1);
        saw_settle = 1'b0;
        saw_en     = 1'b0;
        calib = 1'b1;
        for (int unsigned i = 0; i < plen + 40; i++) begin
            if (i == plen) calib = 1'b0;
            step();
            if (st == 2'd1) saw_settle = 1'b1;
            if (en) saw_en = 1'b1;
        end
        check("t2_saw_settle", saw_settle, 1);
        check("t2_no_clear", saw_en, 0);
        check("t2_state_idle", st, 0);
        check("t2_lost", lost, 0);

        // 3: calibration timeout, then a late calibration
        do_reset();
        ready_mode = 2;
        while (cyc - base < TOUT - 1) step();
        check("t3_timeout_before", tmo, 0);
        step();
        check("t3_timeout_at_limit", tmo, 1);
        check("t3_state_idle", st, 0);
        while (cyc - base < 5000) step();
        check("t3_timeout_sticky", tmo, 1);
        calib = 1'b1;
        push_sweep();
        wait_mrdy(20000);
        check("t3_accepts", acc, DEPTH);
        check("t3_queue_left", exp_q.size(), 0);
        check("t3_timeout_kept", tmo, 1);

        // 4: ready pattern 1,0,0,1 during the sweep
        do_reset();
        ready_mode = 1;
        pat_i = 0;
        hold_chk = 1'b1;
        calib = 1'b1;
        push_sweep();
        wait_mrdy(6000);
        hold_chk = 1'b0;
        check("t4_accepts", acc, DEPTH);
        check("t4_queue_left", exp_q.size(), 0);

        // 5: calibration lost at address 500, then recovered
        do_reset();
        ready_mode = 2;
        calib = 1'b1;
        push_sweep();
        n = 0;
        while (acc < 500 && n < 5000) begin
            step();
            n++;
        end
        check("t5_accepts_before_drop", acc, 500);
        check("t5_addr_at_drop", addr, 500);
        calib = 1'b0;
        ready_mode = 3;
        ready = 1'b0;
        repeat (SYNC + 1) step();
        check("t5_en_after_loss", en, 0);
        check("t5_lost", lost, 1);
        check("t5_state_idle", st, 0);
        check("t5_pending_discarded", exp_q.size(), DEPTH - 500);
        exp_q.delete();
        calib = 1'b1;
        ready_mode = 2;
        push_sweep();
        wait_mrdy(20000);
        check("t5_accepts_restart", acc, DEPTH);
        check("t5_queue_left", exp_q.size(), 0);
        check("t5_lost_kept", lost, 1);

        // 6: asynchronous reset during READY and mid-sweep
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_all_zero("t6_ready_reset");
        exp_q.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        base = cyc;
        ready_mode = 0;
        push_sweep();
        n = 0;
        while (acc < 300 && n < 2000) begin
            step();
            n++;
        end
        check("t6_accepts_before_reset", acc, 300);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_all_zero("t6_clear_reset");
        exp_q.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        push_sweep();
        wait_mrdy(3000);
        check("t6_accepts_full_restart", acc, DEPTH);
        check("t6_queue_left", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
